fetch_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register of the MIPS core.
- Holds the PC and fetches words over a req/ready instruction-memory port.
- Presents the fetched instruction plus its op/funct fields to the decode controller, which sits directly downstream.
- Accepts redirects (branch/jump/jr targets) from execute, a halt request from decode (syscall), and a decode stall.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/fetch_stage_ifid_reg.sv | 70 +++++++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Purpose : shared fetch/decode definitions (fetch FSM states, reset constants, opcode field positions).
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package mips_pkg;

   typedef enum logic [2:0] {
      FS_IDLE,
      FS_FETCH,
      FS_HOLD,
      FS_DRAIN,
      FS_HALT
   } fetch_state_t;

   // Fetched word together with the address it came from.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_word_t;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;   // sll $0,$0,0
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// Purpose : IF/ID slot register plus one-entry skid buffer (load / hold / drain / flush).
// Latency : a load or skid pop appears on o_* one cycle later.
// Backpr. : i_stall freezes the slot; a word arriving while frozen parks in the skid.
// Ports   : i_flush/i_load/i_push/i_pop commands from the fetch FSM, i_stall from decode,
//           i_word = fetched word + its PC, o_valid/o_instr/o_pc/o_pc_plus4 = slot contents.
module ifid_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_flush,
   input  logic        i_load,
   input  logic        i_push,
   input  logic        i_pop,
   input  logic        i_stall,
   input  fetch_word_t i_word,
   output logic        o_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4
);

   logic        r_slot_vld;
   fetch_word_t r_slot;
   logic [31:0] r_pc_plus4;
   logic        r_skid_vld;
   fetch_word_t r_skid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_slot_vld <= 1'b0;
         r_slot     <= '{instr: NOP_INSTR, pc: 32'h0};
         r_pc_plus4 <= 32'h0;
         r_skid_vld <= 1'b0;
         r_skid     <= '0;
      end else if (i_flush) begin
         // PC fields are left as-is; only valid/instr matter for an empty slot.
         r_slot_vld   <= 1'b0;
         r_slot.instr <= NOP_INSTR;
         r_skid_vld   <= 1'b0;
      end else begin
         if (i_load) begin
            r_slot_vld <= 1'b1;
            r_slot     <= i_word;
            r_pc_plus4 <= i_word.pc + 32'd4;
         end else if (i_pop && r_skid_vld) begin
            r_slot_vld <= 1'b1;
            r_slot     <= r_skid;
            r_pc_plus4 <= r_skid.pc + 32'd4;
            r_skid_vld <= 1'b0;
         end else if (!i_stall) begin
            // Decode consumed the slot and nothing replaces it.
            r_slot_vld   <= 1'b0;
            r_slot.instr <= NOP_INSTR;
         end
         if (i_push) begin
            r_skid_vld <= 1'b1;
            r_skid     <= i_word;
         end
      end
   end

   assign o_valid    = r_slot_vld;
   assign o_instr    = r_slot.instr;
   assign o_pc       = r_slot.pc;
   assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Purpose : MIPS instruction fetch (PC + imem req/ready port) feeding the IF/ID register.
// Latency : response accepted in cycle T shows on o_id_* in T+1; 1 instr/cycle with same-cycle ready.
// Backpr. : i_id_stall holds the slot; one extra word parks in the skid and fetching pauses (HOLD).
// Ports   : o_imem_req/o_imem_addr/i_imem_ready/i_imem_rdata = memory port; i_redirect_valid/pc from
//           execute; i_halt_req/i_id_stall from decode; o_id_* = IF/ID slot; o_halted = fetch stopped.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_halt_req,
   input  logic        i_id_stall,
   output logic        o_id_valid,
   output logic [31:0] o_id_instr,
   output logic [5:0]  o_id_op,
   output logic [5:0]  o_id_funct,
   output logic [31:0] o_id_pc,
   output logic [31:0] o_id_pc_plus4,
   output logic        o_halted
);

   fetch_state_t r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic [31:0]  r_req_addr;       // address of the request being drained
   logic         r_halt_pend, w_halt_pend_nxt;
   logic         w_load, w_push, w_pop, w_flush;
   logic         w_busy, w_slot_free;
   fetch_word_t  w_word;

   // In FETCH the PC only moves on ready, so r_pc is the live request address.
   assign w_busy      = (r_state == FS_FETCH) || (r_state == FS_DRAIN);
   assign o_imem_req  = w_busy;
   assign o_imem_addr = (r_state == FS_DRAIN) ? r_req_addr : r_pc;
   assign o_halted    = (r_state == FS_HALT);
   assign w_slot_free = !o_id_valid || !i_id_stall;
   assign w_word      = '{instr: i_imem_rdata, pc: r_pc};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= FS_IDLE;
         r_pc        <= word_align(RESET_PC);
         r_req_addr  <= 32'h0;
         r_halt_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_halt_pend <= w_halt_pend_nxt;
         if (r_state == FS_FETCH) begin
            r_req_addr <= r_pc;
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_halt_pend_nxt = r_halt_pend;
      w_load          = 1'b0;
      w_push          = 1'b0;
      w_pop           = 1'b0;
      w_flush         = 1'b0;

      case (r_state)
         FS_IDLE: w_state_nxt = FS_FETCH;
         FS_FETCH: begin
            if (i_imem_ready) begin
               w_pc_nxt = r_pc + 32'd4;
               if (w_slot_free) begin
                  w_load = 1'b1;
               end else begin
                  w_push      = 1'b1;
                  w_state_nxt = FS_HOLD;
               end
            end
         end
         FS_HOLD: begin
            if (!i_id_stall) begin
               w_pop       = 1'b1;
               w_state_nxt = FS_FETCH;
            end
         end
         FS_DRAIN: begin
            if (i_imem_ready) begin
               w_halt_pend_nxt = 1'b0;
               w_state_nxt     = r_halt_pend ? FS_HALT : FS_FETCH;
            end
         end
         FS_HALT: begin
         end
         default: w_state_nxt = FS_IDLE;
      endcase

      // Redirect beats halt; both are ignored once halted.
      if (r_state != FS_HALT) begin
         if (i_redirect_valid) begin
            w_flush         = 1'b1;
            w_load          = 1'b0;
            w_push          = 1'b0;
            w_pop           = 1'b0;
            w_halt_pend_nxt = 1'b0;
            w_pc_nxt        = word_align(i_redirect_pc);
            w_state_nxt     = (w_busy && !i_imem_ready) ? FS_DRAIN : FS_FETCH;
         end else if (i_halt_req) begin
            w_load   = 1'b0;
            w_push   = 1'b0;
            w_pop    = 1'b0;
            w_pc_nxt = r_pc;
            if (w_busy && !i_imem_ready) begin
               w_halt_pend_nxt = 1'b1;
               w_state_nxt     = FS_DRAIN;
            end else begin
               w_halt_pend_nxt = 1'b0;
               w_state_nxt     = FS_HALT;
            end
         end
      end
   end

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_flush    (w_flush),
      .i_load     (w_load),
      .i_push     (w_push),
      .i_pop      (w_pop),
      .i_stall    (i_id_stall),
      .i_word     (w_word),
      .o_valid    (o_id_valid),
      .o_instr    (o_id_instr),
      .o_pc       (o_id_pc),
      .o_pc_plus4 (o_id_pc_plus4)
   );

   assign o_id_op    = o_id_instr[OP_MSB:OP_LSB];
   assign o_id_funct = o_id_instr[FUNCT_MSB:FUNCT_LSB];

endmodule
